// File: rtl/vc_fifo_if.sv
// rtl/vc_fifo_if.sv - push/pop handshake and status bundle for one virtual-channel FIFO
interface vc_fifo_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  fifo_error;

  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, count, full, empty, almost_full, almost_empty, fifo_error
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, count, full, empty, almost_full, almost_empty, fifo_error
  );
endinterface

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - per-VC FIFO with registered read, occupancy flags and illegal-access error
// Define VC_FIFO_ERR_STICKY_EN to make fifo_error latch until reset instead of pulsing.
module vc_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic      clk,
  input  logic      reset,
  vc_fifo_if.slave  bus
);
  localparam int                  DEPTH_N   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH     = DEPTH_N[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_LVL    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL    = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_N];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic full_w, empty_w;
  logic push_ok, pop_ok, err_evt;

  assign full_w  = (count_q == DEPTH);
  assign empty_w = (count_q == '0);

  // A full FIFO still takes a push when the same cycle frees a slot; an empty one never bypasses.
  assign pop_ok  = bus.pop & ~empty_w;
  assign push_ok = bus.push & (~full_w | pop_ok);
  assign err_evt = (bus.push & full_w & ~bus.pop) | (bus.pop & empty_w);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = '0;
    valid_d    = 1'b0;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q];
      valid_d    = 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
`ifdef VC_FIFO_ERR_STICKY_EN
    err_d = err_q | err_evt;
`else
    err_d = err_evt;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Storage is left uninitialised; occupancy gating keeps stale entries unobservable.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_LVL);
  assign bus.almost_empty = (count_q <= AE_LVL);
  assign bus.fifo_error   = err_q;
endmodule

// File: tb/tb_vc_fifo.sv
// tb/tb_vc_fifo.sv - directed self-checking bench for vc_fifo
module tb_vc_fifo;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  vc_fifo_if #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) bus ();

  vc_fifo #(.DATA_WIDTH(6), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef VC_FIFO_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic fill4(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c, input logic [5:0] d);
    bus.push = 1'b1;
    bus.data_in = a; tick();
    bus.data_in = b; tick();
    bus.data_in = c; tick();
    bus.data_in = d; tick();
    bus.push = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (5) tick();
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    n_cmp++; if (bus.almost_empty !== 1'b1) begin n_bad++; $display("FAIL reset_ae got %b exp 1", bus.almost_empty); end
    n_cmp++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_full_af got %b%b exp 00", bus.full, bus.almost_full); end
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    n_cmp++; if (bus.valid_out !== 1'b0 || bus.data_out !== 6'h00) begin n_bad++; $display("FAIL reset_out got v=%b d=%h exp v=0 d=00", bus.valid_out, bus.data_out); end
    n_cmp++; if (bus.fifo_error !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", bus.fifo_error); end
  endtask

  task automatic test_fill_drain();
    logic [5:0] w [4];
    w[0] = 6'h21; w[1] = 6'h05; w[2] = 6'h3F; w[3] = 6'h10;
    do_reset();
    bus.push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data_in = w[i];
      tick();
      n_cmp++; if (bus.count !== 3'(i + 1)) begin n_bad++; $display("FAIL fill_count%0d got %0d exp %0d", i, bus.count, i + 1); end
      n_cmp++; if (bus.almost_full !== (i >= 2)) begin n_bad++; $display("FAIL fill_af%0d got %b exp %b", i, bus.almost_full, (i >= 2)); end
      n_cmp++; if (bus.full !== (i == 3)) begin n_bad++; $display("FAIL fill_full%0d got %b exp %b", i, bus.full, (i == 3)); end
    end
    bus.push = 1'b0;
    bus.pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== w[i]) begin n_bad++; $display("FAIL drain%0d got v=%b d=%h exp v=1 d=%h", i, bus.valid_out, bus.data_out, w[i]); end
      n_cmp++; if (bus.count !== 3'(3 - i)) begin n_bad++; $display("FAIL drain_count%0d got %0d exp %0d", i, bus.count, 3 - i); end
    end
    bus.pop = 1'b0;
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %b exp 1", bus.empty); end
    tick();
    n_cmp++; if (bus.valid_out !== 1'b0 || bus.data_out !== 6'h00) begin n_bad++; $display("FAIL idle_out got v=%b d=%h exp v=0 d=00", bus.valid_out, bus.data_out); end
  endtask

  task automatic test_overflow();
    logic [5:0] w [4];
    w[0] = 6'h01; w[1] = 6'h22; w[2] = 6'h03; w[3] = 6'h24;
    do_reset();
    fill4(w[0], w[1], w[2], w[3]);
    bus.push = 1'b1; bus.data_in = 6'h2A;
    tick();
    bus.push = 1'b0;
    n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL ovf_count got %0d exp 4", bus.count); end
    n_cmp++; if (bus.fifo_error !== 1'b1) begin n_bad++; $display("FAIL ovf_err got %b exp 1", bus.fifo_error); end
    tick();
    n_cmp++; if (bus.fifo_error !== STICKY) begin n_bad++; $display("FAIL ovf_err_after got %b exp %b", bus.fifo_error, STICKY); end
    bus.pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== w[i]) begin n_bad++; $display("FAIL ovf_drain%0d got v=%b d=%h exp v=1 d=%h", i, bus.valid_out, bus.data_out, w[i]); end
    end
    tick();
    bus.pop = 1'b0;
    n_cmp++; if (bus.valid_out !== 1'b0 || bus.empty !== 1'b1) begin n_bad++; $display("FAIL ovf_extra got v=%b e=%b exp v=0 e=1", bus.valid_out, bus.empty); end
  endtask

  task automatic test_push_pop_full();
    logic [5:0] w [5];
    w[0] = 6'h11; w[1] = 6'h22; w[2] = 6'h33; w[3] = 6'h34; w[4] = 6'h07;
    do_reset();
    fill4(w[0], w[1], w[2], w[3]);
    bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = w[4];
    tick();
    bus.push = 1'b0;
    n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== w[0]) begin n_bad++; $display("FAIL ppfull_out got v=%b d=%h exp v=1 d=%h", bus.valid_out, bus.data_out, w[0]); end
    n_cmp++; if (bus.count !== 3'd4 || bus.fifo_error !== 1'b0) begin n_bad++; $display("FAIL ppfull_cnt_err got c=%0d e=%b exp c=4 e=0", bus.count, bus.fifo_error); end
    for (int i = 1; i < 5; i++) begin
      tick();
      n_cmp++; if (bus.data_out !== w[i]) begin n_bad++; $display("FAIL ppfull_drain%0d got %h exp %h", i, bus.data_out, w[i]); end
    end
    bus.pop = 1'b0;
  endtask

  task automatic test_push_pop_empty();
    do_reset();
    bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 6'h12;
    tick();
    bus.push = 1'b0;
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL ppempty_valid got %b exp 0", bus.valid_out); end
    n_cmp++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL ppempty_count got %0d exp 1", bus.count); end
    n_cmp++; if (bus.fifo_error !== 1'b1) begin n_bad++; $display("FAIL ppempty_err got %b exp 1", bus.fifo_error); end
    tick();
    bus.pop = 1'b0;
    n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== 6'h12) begin n_bad++; $display("FAIL ppempty_next got v=%b d=%h exp v=1 d=12", bus.valid_out, bus.data_out); end
    n_cmp++; if (bus.fifo_error !== STICKY) begin n_bad++; $display("FAIL ppempty_err_after got %b exp %b", bus.fifo_error, STICKY); end
  endtask

  task automatic test_wrap_reset();
    logic [5:0] w [10];
    for (int i = 0; i < 10; i++) w[i] = 6'(6'h30 + i);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.push = 1'b1; bus.data_in = w[i]; bus.pop = (i >= 2);
      tick();
      if (i >= 2) begin
        n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== w[i-2]) begin n_bad++; $display("FAIL wrap%0d got v=%b d=%h exp v=1 d=%h", i, bus.valid_out, bus.data_out, w[i-2]); end
      end
    end
    bus.push = 1'b0; bus.pop = 1'b1;
    for (int i = 8; i < 10; i++) begin
      tick();
      n_cmp++; if (bus.data_out !== w[i]) begin n_bad++; $display("FAIL wrap_tail%0d got %h exp %h", i, bus.data_out, w[i]); end
    end
    bus.pop = 1'b0;
    n_cmp++; if (bus.empty !== 1'b1 || bus.fifo_error !== 1'b0) begin n_bad++; $display("FAIL wrap_end got e=%b err=%b exp e=1 err=0", bus.empty, bus.fifo_error); end
    bus.push = 1'b1;
    bus.data_in = 6'h01; tick();
    bus.data_in = 6'h02; tick();
    bus.data_in = 6'h03; tick();
    bus.push = 1'b0; bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.almost_full !== 1'b0) begin n_bad++; $display("FAIL midrst_flags got c=%0d e=%b af=%b exp c=0 e=1 af=0", bus.count, bus.empty, bus.almost_full); end
    n_cmp++; if (bus.valid_out !== 1'b0 || bus.data_out !== 6'h00) begin n_bad++; $display("FAIL midrst_out got v=%b d=%h exp v=0 d=00", bus.valid_out, bus.data_out); end
    tick();
    reset = 1'b0;
    bus.push = 1'b1; bus.data_in = 6'h3C;
    tick();
    bus.push = 1'b0;
    n_cmp++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL postrst_count got %0d exp 1", bus.count); end
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== 6'h3C) begin n_bad++; $display("FAIL postrst_data got v=%b d=%h exp v=1 d=3c", bus.valid_out, bus.data_out); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL postrst_empty got %b exp 1", bus.empty); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_push_pop_full();
    test_push_pop_empty();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
